// File: rtl/rs_issue_scheduler_if.sv
// ALU-side issue bundle and handshake between the scheduler and the ALU/CDB driver.
package rs_issue_pkg;
    typedef struct packed {
        logic [2:0]  tag;    // ROB tag, indexes allocated_rob_entries
        logic [3:0]  op;
        logic [15:0] src_a;
        logic [15:0] src_b;
    } alu_word_t;
endpackage

interface rs_issue_scheduler_if;
    import rs_issue_pkg::*;
    logic      valid;
    logic      ready;
    alu_word_t data;
    logic      ld_pc;

    modport master (output valid, output data, output ld_pc, input ready);
    modport slave  (input valid, input data, input ld_pc, output ready);
endinterface

// File: rtl/rs_issue_scheduler.sv
// Reservation-station dispatch steering plus round-robin issue into a
// single-entry registered issue stage feeding one shared ALU.
module rs_issue_scheduler
    import rs_issue_pkg::*;
#(
    parameter int NUM_RS = 5,
    parameter int PTR_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_ip,
    input  logic                    dispatch_valid,
    output logic                    dispatch_ready,
    output logic [NUM_RS-1:0]       rs_load,
    input  logic [NUM_RS-1:0]       rs_empty,
    input  logic [NUM_RS-1:0]       rs_req,
    input  alu_word_t [NUM_RS-1:0]  rs_alu_data,
    input  logic [NUM_RS-1:0]       rs_ld_pc,
    output logic [NUM_RS-1:0]       rs_grant,
    input  logic [7:0]              allocated_rob_entries,
    rs_issue_scheduler_if.master    alu,
    output logic [CNT_W-1:0]        stall_cnt
);

    logic              issue_valid;
    alu_word_t         issue_data;
    logic              issue_ld_pc;
    logic [PTR_W-1:0]  rr_ptr;
    logic [CNT_W-1:0]  stall_q;

    logic              live;
    logic              accept;
    logic              alu_valid_int;

    logic              grant_any;
    logic [NUM_RS-1:0] grant_vec;
    logic [PTR_W-1:0]  nxt_ptr;
    alu_word_t         sel_data;
    logic              sel_ld_pc;
    int                scan_idx;

    logic [NUM_RS-1:0] load_vec;
    logic              load_found;

    // An op whose ROB entry vanished (flush) is dead: never shown, freely replaced.
    assign live          = allocated_rob_entries[issue_data.tag];
    assign accept        = ~flush_ip & (~issue_valid | alu.ready | ~live);
    assign alu_valid_int = issue_valid & live;

    assign alu.valid      = alu_valid_int;
    assign alu.data       = issue_data;
    assign alu.ld_pc      = issue_ld_pc;
    assign stall_cnt      = stall_q;
    assign dispatch_ready = (|rs_empty) & ~flush_ip;
    assign rs_load        = load_vec;
    assign rs_grant       = grant_vec;

    // Dispatch: steer the incoming word to the lowest-index empty station.
    always_comb begin
        load_vec   = '0;
        load_found = 1'b0;
        if (rst && dispatch_valid && !flush_ip) begin
            for (int i = 0; i < NUM_RS; i++) begin
                if (!load_found && rs_empty[i]) begin
                    load_vec[i] = 1'b1;
                    load_found  = 1'b1;
                end
            end
        end
    end

    // Issue arbitration: first requester scanning upward from rr_ptr, wrapping.
    always_comb begin
        grant_vec = '0;
        grant_any = 1'b0;
        nxt_ptr   = rr_ptr;
        sel_data  = '0;
        sel_ld_pc = 1'b0;
        scan_idx  = 0;
        if (rst && accept) begin
            for (int i = 0; i < NUM_RS; i++) begin
                scan_idx = int'(rr_ptr) + i;
                if (scan_idx >= NUM_RS) scan_idx = scan_idx - NUM_RS;
                if (!grant_any && rs_req[scan_idx]) begin
                    grant_any           = 1'b1;
                    grant_vec[scan_idx] = 1'b1;
                    sel_data            = rs_alu_data[scan_idx];
                    sel_ld_pc           = rs_ld_pc[scan_idx];
                    nxt_ptr             = PTR_W'((scan_idx + 1 == NUM_RS) ? 0 : scan_idx + 1);
                end
            end
        end
    end

    // Issue register: load on grant, drain on transfer / dead op / flush, else hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_valid <= 1'b0;
            issue_data  <= '0;
            issue_ld_pc <= 1'b0;
            rr_ptr      <= '0;
        end else if (grant_any) begin
            issue_valid <= 1'b1;
            issue_data  <= sel_data;
            issue_ld_pc <= sel_ld_pc;
            rr_ptr      <= nxt_ptr;
        end else if (alu.ready || !live || flush_ip) begin
            issue_valid <= 1'b0;
        end
    end

    // Saturating count of cycles the ALU back-pressures a presented op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (alu_valid_int && !alu.ready && !(&stall_q)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

endmodule
